// File: rtl/stream_arb_pkg.sv
// Shared types for the two-channel stream arbiter: channel tag and channel count.
package stream_arb_pkg;
   typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ch_tag_t;
   localparam int NUM_CH = 2;
endpackage

// File: rtl/arb_tag_queue.sv
// Circular FIFO of channel tags, one per sample held by the shared unit.
module arb_tag_queue
   import stream_arb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  ch_tag_t       tag_i,
   input  logic          pop_i,
   output ch_tag_t       head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);
   localparam int AW = $clog2(DEPTH);

   ch_tag_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= tag_i;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/stream_rr_arbiter.sv
// Two-channel round-robin front end for a shared in-order unit: stages one sample,
// tags everything consumed, and steers each result back to its source channel.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] ch0_din,
   input  logic [DATA_WIDTH-1:0] ch1_din,
   input  logic                  ch0_empty,
   input  logic                  ch1_empty,
   output logic                  ch0_rd_en,
   output logic                  ch1_rd_en,
   output logic [DATA_WIDTH-1:0] unit_din,
   output logic                  unit_empty,
   input  logic                  unit_rd_en,
   input  logic [DATA_WIDTH-1:0] unit_dout,
   input  logic                  unit_wr_en,
   output logic                  unit_full,
   output logic [DATA_WIDTH-1:0] ch0_out_din,
   output logic [DATA_WIDTH-1:0] ch1_out_din,
   output logic                  ch0_out_wr_en,
   output logic                  ch1_out_wr_en,
   input  logic                  ch0_out_full,
   input  logic                  ch1_out_full,
   output logic                  err
);
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic                  stage_valid_q, stage_valid_d;
   logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
   ch_tag_t               stage_tag_q, stage_tag_d;
   ch_tag_t               last_grant_q, last_grant_d;
   logic                  err_q, err_d;

   logic          consume, load, ret_ok;
   ch_tag_t       grant, tag_head;
   logic [CW-1:0] tag_count, outstanding;
   logic          tag_empty, tag_full;

   arb_tag_queue #(.DEPTH(MAX_OUTSTANDING), .CW(CW)) u_tags (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (consume),
      .tag_i   (stage_tag_q),
      .pop_i   (ret_ok),
      .head_o  (tag_head),
      .count_o (tag_count),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );

   assign consume     = unit_rd_en & stage_valid_q;
   assign outstanding = tag_count + CW'(stage_valid_q);
   // Limit uses the registered count, so a same-cycle tag pop does not free a slot yet.
   assign load        = (!stage_valid_q | consume) & (outstanding < CW'(MAX_OUTSTANDING))
                      & (!ch0_empty | !ch1_empty);

   always_comb begin
      grant = CH0;
      if (!ch0_empty && !ch1_empty) grant = (last_grant_q == CH0) ? CH1 : CH0;
      else if (ch0_empty)           grant = CH1;
   end

   assign ch0_rd_en = load & (grant == CH0);
   assign ch1_rd_en = load & (grant == CH1);

   always_comb begin
      stage_valid_d = stage_valid_q;
      stage_data_d  = stage_data_q;
      stage_tag_d   = stage_tag_q;
      last_grant_d  = last_grant_q;
      if (load) begin
         stage_valid_d = 1'b1;
         stage_data_d  = (grant == CH0) ? ch0_din : ch1_din;
         stage_tag_d   = grant;
         last_grant_d  = grant;
      end else if (consume) begin
         stage_valid_d = 1'b0;
      end
   end

   assign unit_full     = tag_empty | ((tag_head == CH0) ? ch0_out_full : ch1_out_full);
   assign ret_ok        = unit_wr_en & !unit_full;
   assign ch0_out_wr_en = ret_ok & (tag_head == CH0);
   assign ch1_out_wr_en = ret_ok & (tag_head == CH1);
   assign ch0_out_din   = unit_dout;
   assign ch1_out_din   = unit_dout;
   assign err_d         = err_q | (unit_wr_en & unit_full);

   always_ff @(posedge clock) begin
      if (reset) begin
         stage_valid_q <= 1'b0;
         stage_data_q  <= '0;
         stage_tag_q   <= CH0;
         last_grant_q  <= CH1;
         err_q         <= 1'b0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_data_q  <= stage_data_d;
         stage_tag_q   <= stage_tag_d;
         last_grant_q  <= last_grant_d;
         err_q         <= err_d;
      end
   end

   assign unit_din   = stage_data_q;
   assign unit_empty = !stage_valid_q;
   assign err        = err_q;

   logic unused_full;
   assign unused_full = tag_full;
endmodule
